// File: rtl/alu_pkg.sv
// Shared ALU control codes, ARM data-processing opcodes and sequencer FSM states.
// Used by the ALU front-end sequencer and its opcode decoder.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Purpose: map an ARM data-processing opcode and operands onto ALU operands/control.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             wb,
    output logic             err
);

    always_comb begin
        alu_a    = a;
        alu_b    = b;
        alu_ctrl = ALU_AND;
        wb       = 1'b1;
        err      = 1'b0;
        case (opcode)
            OP_AND: alu_ctrl = ALU_AND;
            OP_EOR: alu_ctrl = ALU_XOR;
            OP_SUB: alu_ctrl = ALU_SUB;
            OP_RSB: begin alu_a = b; alu_b = a; alu_ctrl = ALU_SUB; end
            OP_ADD: alu_ctrl = ALU_ADD;
            OP_TST: begin alu_ctrl = ALU_AND; wb = 1'b0; end
            OP_TEQ: begin alu_ctrl = ALU_XOR; wb = 1'b0; end
            OP_CMP: begin alu_ctrl = ALU_SUB; wb = 1'b0; end
            OP_CMN: begin alu_ctrl = ALU_ADD; wb = 1'b0; end
            OP_ORR: alu_ctrl = ALU_OR;
            OP_MOV: begin alu_a = '0; alu_ctrl = ALU_OR; end
            OP_BIC: begin alu_b = ~b; alu_ctrl = ALU_AND; end
            OP_MVN: begin alu_a = b; alu_b = '1; alu_ctrl = ALU_XOR; end
            // ADC/SBC/RSC need a carry-in the ALU does not have
            default: begin alu_a = '0; alu_b = '0; wb = 1'b0; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: valid/ready front end for the ALU; optional shift-add MUL via macro ALU_SEQ_MUL_EN.
// Latency: response 2 cycles after accept (error 1, MUL 34); one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic             req_mul,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_wb,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_operand_a,
    output logic [WIDTH-1:0] alu_operand_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] dec_a, dec_b;
    logic [3:0]       dec_ctrl;
    logic             dec_wb, dec_err;
    logic             req_bad;

    alu_op_decode #(.WIDTH(WIDTH)) u_decode (
        .opcode   (req_opcode),
        .a        (req_a),
        .b        (req_b),
        .alu_a    (dec_a),
        .alu_b    (dec_b),
        .alu_ctrl (dec_ctrl),
        .wb       (dec_wb),
        .err      (dec_err)
    );

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    mul_cnt;
    logic             mul_pend;
    logic             mul_zero;
    logic             mul_last;

    assign req_bad  = !req_mul && dec_err;
    assign mul_last = (mul_cnt == CW'(WIDTH - 1));
`else
    assign req_bad  = req_mul || dec_err;
`endif

    assign rsp_neg = rsp_result[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_bad ? S_RESP : S_EXEC;
            end
`ifdef ALU_SEQ_MUL_EN
            S_EXEC: state_nxt = mul_pend ? S_MUL : S_RESP;
            S_MUL:  if (mul_last) state_nxt = S_RESP;
`else
            S_EXEC: state_nxt = S_RESP;
`endif
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
            rsp_wb        <= 1'b0;
            rsp_err       <= 1'b0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_control   <= ALU_AND;
`ifdef ALU_SEQ_MUL_EN
            mplier        <= '0;
            mul_cnt       <= '0;
            mul_pend      <= 1'b0;
            mul_zero      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    mul_pend <= req_mul;
`endif
                    // Rejected requests leave the ALU ports untouched
                    if (req_bad) begin
                        rsp_result <= '0;
                        rsp_zero   <= 1'b1;
                        rsp_wb     <= 1'b0;
                        rsp_err    <= 1'b1;
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (req_mul) begin
                        alu_operand_a <= '0;
                        alu_operand_b <= req_a;
                        alu_control   <= ALU_ADD;
                        mplier        <= req_b;
                        mul_cnt       <= '0;
                        mul_zero      <= 1'b1;
                        rsp_wb        <= 1'b1;
                        rsp_err       <= 1'b0;
                    end
`endif
                    else begin
                        alu_operand_a <= dec_a;
                        alu_operand_b <= dec_b;
                        alu_control   <= dec_ctrl;
                        rsp_wb        <= dec_wb;
                        rsp_err       <= 1'b0;
                    end
                end
                S_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                end
`ifdef ALU_SEQ_MUL_EN
                // operand_a doubles as the accumulator; operand_b walks req_a << i
                S_MUL: begin
                    if (mplier[0]) begin
                        alu_operand_a <= alu_result;
                        mul_zero      <= alu_zero;
                    end
                    alu_operand_b <= alu_operand_b << 1;
                    mplier        <= mplier >> 1;
                    mul_cnt       <= mul_cnt + CW'(1);
                    if (mul_last) begin
                        rsp_result <= mplier[0] ? alu_result : alu_operand_a;
                        rsp_zero   <= mplier[0] ? alu_zero : mul_zero;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random requests checked against an opcode-level reference model.
// Includes a behavioural ALU on the alu_* ports.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_opcode = 4'd0;
    logic        req_mul = 1'b0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_neg, rsp_wb, rsp_err;
    logic [31:0] alu_operand_a, alu_operand_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_mul(req_mul), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_wb(rsp_wb), .rsp_err(rsp_err),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Combinational ALU the sequencer is meant to drive
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_operand_a & alu_operand_b;
            4'b0001: alu_result = alu_operand_a | alu_operand_b;
            4'b0010: alu_result = alu_operand_a + alu_operand_b;
            4'b0011: alu_result = alu_operand_a - alu_operand_b;
            4'b0100: alu_result = ($signed(alu_operand_a) < $signed(alu_operand_b)) ? 32'd1 : 32'd0;
            4'b0101: alu_result = alu_operand_a ^ alu_operand_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural meaning of each request, independent of ALU encodings
    function automatic void model(input logic [3:0] op, input logic mul,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic wb, output logic err);
        r = 32'd0; wb = 1'b1; err = 1'b0;
        if (mul) begin
`ifdef ALU_SEQ_MUL_EN
            r = a * b;
`else
            wb = 1'b0; err = 1'b1;
`endif
        end else begin
            case (op)
                4'd0:  r = a & b;
                4'd1:  r = a ^ b;
                4'd2:  r = a - b;
                4'd3:  r = b - a;
                4'd4:  r = a + b;
                4'd8:  begin r = a & b; wb = 1'b0; end
                4'd9:  begin r = a ^ b; wb = 1'b0; end
                4'd10: begin r = a - b; wb = 1'b0; end
                4'd11: begin r = a + b; wb = 1'b0; end
                4'd12: r = a | b;
                4'd13: r = b;
                4'd14: r = a & ~b;
                4'd15: r = ~b;
                default: begin wb = 1'b0; err = 1'b1; end
            endcase
        end
    endfunction

    task automatic run_req(input logic [3:0] op, input logic mul,
                           input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er, pa, pb, hr;
        logic [3:0]  pc;
        logic        ewb, eerr;
        int          n, lat, exp_lat;
        model(op, mul, a, b, er, ewb, eerr);
        exp_lat = eerr ? 0 : (mul ? 33 : 1);
        pa = alu_operand_a; pb = alu_operand_b; pc = alu_control;
        req_opcode = op; req_mul = mul; req_a = a; req_b = b; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_opcode = 4'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("latency", lat, exp_lat);
        check("result", rsp_result, er);
        check("zero", {31'd0, rsp_zero}, {31'd0, er == 32'd0});
        check("neg", {31'd0, rsp_neg}, {31'd0, er[31]});
        check("wb", {31'd0, rsp_wb}, {31'd0, ewb});
        check("err", {31'd0, rsp_err}, {31'd0, eerr});
        check("busy_ready", {31'd0, req_ready}, 32'd0);
        if (eerr) begin
            check("alu_a_kept", alu_operand_a, pa);
            check("alu_b_kept", alu_operand_b, pb);
            check("alu_ctl_kept", {28'd0, alu_control}, {28'd0, pc});
        end
        hr = rsp_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_result", rsp_result, hr);
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("done_valid", {31'd0, rsp_valid}, 32'd0);
        check("done_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        logic mul_en;
`ifdef ALU_SEQ_MUL_EN
        mul_en = 1'b1;
`else
        mul_en = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_flags", {28'd0, rsp_zero, rsp_neg, rsp_wb, rsp_err}, 32'd0);
        check("rst_alu_a", alu_operand_a, 32'd0);
        check("rst_alu_b", alu_operand_b, 32'd0);
        check("rst_alu_ctl", {28'd0, alu_control}, 32'd0);

        run_req(4'b0100, 1'b0, 32'd5, 32'd7, 0);            // ADD
        run_req(4'b1010, 1'b0, 32'd9, 32'd9, 0);            // CMP
        run_req(4'b0011, 1'b0, 32'd3, 32'd10, 1);           // RSB
        run_req(4'b1111, 1'b0, 32'd123, 32'd0, 0);          // MVN
        run_req(4'b1110, 1'b0, 32'hFF, 32'h0F, 0);          // BIC
        run_req(4'b1101, 1'b0, 32'hDEAD, 32'h55, 0);        // MOV
        run_req(4'b0101, 1'b0, 32'h1111, 32'h2222, 5);      // ADC
        run_req(4'b0000, 1'b1, 32'h1234, 32'h10, 0);        // MUL
        run_req(4'b0000, 1'b1, 32'hFFFFFFFF, 32'd2, 2);     // MUL
        run_req(4'b0000, 1'b1, 32'h0, 32'hFFFFFFFF, 0);     // MUL to zero

        // Reset while an operation is in flight
        req_opcode = 4'b0100; req_mul = mul_en; req_a = 32'd77; req_b = 32'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (mul_en) repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        check("midrst_no_rsp", seen, 0);
        run_req(4'b0100, 1'b0, 32'd1, 32'd1, 0);            // ADD 1+1

        for (int k = 0; k < 40; k++)
            run_req(4'($urandom_range(15)), ($urandom_range(5) == 0),
                    $urandom, (k % 4 == 0) ? 32'($urandom_range(3)) : $urandom,
                    $urandom_range(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
